// File: rtl/fs_port_arbiter.sv
// fs_port_arbiter: two-requester whole-transaction arbiter for the filesystem backing-store port,
// round-robin on release with a one-cycle drain so a final read still returns to its owner.
module fs_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_access,
  input  logic              m0_rden,
  input  logic              m0_wren,
  input  logic              m0_meta,
  input  logic [AW-1:0]     m0_address,
  input  logic [DW-1:0]     m0_data,
  output logic [DW-1:0]     m0_q,
  output logic              m0_grant,
  input  logic              m1_access,
  input  logic              m1_rden,
  input  logic              m1_wren,
  input  logic              m1_meta,
  input  logic [AW-1:0]     m1_address,
  input  logic [DW-1:0]     m1_data,
  output logic [DW-1:0]     m1_q,
  output logic              m1_grant,
  output logic              fs_access,
  output logic              fs_rden,
  output logic              fs_wren,
  output logic              fs_meta,
  output logic [AW-1:0]     fs_address,
  output logic [DW-1:0]     fs_data,
  input  logic [DW-1:0]     fs_q,
  output logic              protocol_err,
  output logic [WCNT_W-1:0] m0_wait,
  output logic [WCNT_W-1:0] m1_wait
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;
  state_t state_q, state_d;
  logic last_owner_q, last_owner_d, drain_owner_q, drain_owner_d, perr_q, perr_d;
  logic [WCNT_W-1:0] m0_wait_q, m0_wait_d, m1_wait_q, m1_wait_d;
  logic g0, g1, dr, own_rd, own_wr;
  assign g0 = state_q == GRANT0;
  assign g1 = state_q == GRANT1;
  assign dr = state_q == DRAIN;
  assign own_rd = g0 ? m0_rden : g1 ? m1_rden : 1'b0;
  assign own_wr = g0 ? m0_wren : g1 ? m1_wren : 1'b0;
  assign m0_grant = g0;
  assign m1_grant = g1;
  assign fs_access = g0 | g1 | dr;
  assign fs_wren = own_wr;
  assign fs_rden = own_rd & ~own_wr;
  assign fs_meta = g0 ? m0_meta : g1 ? m1_meta : 1'b0;
  assign fs_address = g0 ? m0_address : g1 ? m1_address : '0;
  assign fs_data = g0 ? m0_data : g1 ? m1_data : '0;
  // Drain keeps read data flowing to the previous owner for its last-cycle read.
  assign m0_q = (g0 | (dr & ~drain_owner_q)) ? fs_q : '0;
  assign m1_q = (g1 | (dr & drain_owner_q)) ? fs_q : '0;
  assign protocol_err = perr_q;
  assign m0_wait = m0_wait_q;
  assign m1_wait = m1_wait_q;
  always_comb begin
    state_d = state_q;
    last_owner_d = last_owner_q;
    drain_owner_d = drain_owner_q;
    if (state_q == IDLE || dr) begin
      if (m0_access && (!m1_access || last_owner_q)) state_d = GRANT0;
      else if (m1_access) state_d = GRANT1;
      else state_d = IDLE;
    end else if ((g0 && !m0_access) || (g1 && !m1_access)) begin
      state_d = DRAIN;
      last_owner_d = g1;
      drain_owner_d = g1;
    end
    perr_d = perr_q | (!g0 && (m0_rden || m0_wren)) | (!g1 && (m1_rden || m1_wren)) | (own_rd && own_wr);
    m0_wait_d = (!m0_access || g0 || state_d == GRANT0) ? '0 : (&m0_wait_q) ? m0_wait_q : m0_wait_q + WCNT_W'(1);
    m1_wait_d = (!m1_access || g1 || state_d == GRANT1) ? '0 : (&m1_wait_q) ? m1_wait_q : m1_wait_q + WCNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_owner_q <= 1'b1;
      drain_owner_q <= 1'b0;
      perr_q <= 1'b0;
      m0_wait_q <= '0;
      m1_wait_q <= '0;
    end else begin
      state_q <= state_d;
      last_owner_q <= last_owner_d;
      drain_owner_q <= drain_owner_d;
      perr_q <= perr_d;
      m0_wait_q <= m0_wait_d;
      m1_wait_q <= m1_wait_d;
    end
  end
endmodule

// File: tb/tb_fs_port_arbiter.sv
// tb_fs_port_arbiter: per-cycle vector table for grant/handover/drain behaviour plus
// hand-written sequences for tie-break, rden&wren conflict, wait saturation and async reset.
module tb_fs_port_arbiter;
  localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_access = 0, m0_rden = 0, m0_wren = 0, m0_meta = 0;
  logic m1_access = 0, m1_rden = 0, m1_wren = 0, m1_meta = 0;
  logic [31:0] m0_address = 0, m1_address = 0, m0_data = D0, m1_data = D1, fs_q = 0;
  logic [31:0] m0_q, m1_q, fs_address, fs_data;
  logic m0_grant, m1_grant, fs_access, fs_rden, fs_wren, fs_meta, protocol_err;
  logic [15:0] m0_wait, m1_wait;
  int nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  fs_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_access(m0_access), .m0_rden(m0_rden), .m0_wren(m0_wren), .m0_meta(m0_meta),
    .m0_address(m0_address), .m0_data(m0_data), .m0_q(m0_q), .m0_grant(m0_grant),
    .m1_access(m1_access), .m1_rden(m1_rden), .m1_wren(m1_wren), .m1_meta(m1_meta),
    .m1_address(m1_address), .m1_data(m1_data), .m1_q(m1_q), .m1_grant(m1_grant),
    .fs_access(fs_access), .fs_rden(fs_rden), .fs_wren(fs_wren), .fs_meta(fs_meta),
    .fs_address(fs_address), .fs_data(fs_data), .fs_q(fs_q),
    .protocol_err(protocol_err), .m0_wait(m0_wait), .m1_wait(m1_wait)
  );
  typedef struct {
    logic a0, rd0, wr0, a1, rd1, wr1;
    logic [31:0] ad0, ad1, fsq;
    logic g0, g1, acc, rd, wr, bus;
    logic [31:0] ad, dt, q0, q1;
    logic pe;
    logic [15:0] wt1;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {m0_access, m0_rden, m0_wren, m0_meta, m1_access, m1_rden, m1_wren, m1_meta} = '0;
    m0_address = 0;
    m1_address = 0;
    fs_q = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask
  initial begin
    v[0]  = '{0,0,0,0,0,0, 0,0,0,            0,0,0,0,0,1, 0,0,0,0,                   0,0};
    v[1]  = '{1,0,0,1,0,0, 0,0,32'hAAAA5555, 0,0,0,0,0,1, 0,0,0,0,                   0,0};
    v[2]  = '{1,1,0,1,0,0, 32'h40,0,0,       1,0,1,1,0,1, 32'h40,D0,0,0,             0,1};
    v[3]  = '{1,0,0,1,0,0, 0,0,32'hDEADBEEF, 1,0,1,0,0,1, 0,D0,32'hDEADBEEF,0,       0,2};
    v[4]  = '{0,1,0,1,0,0, 32'h44,0,0,       1,0,1,1,0,1, 32'h44,D0,0,0,             0,3};
    v[5]  = '{0,0,0,1,0,0, 0,0,32'hCAFEF00D, 0,0,1,0,0,0, 0,0,32'hCAFEF00D,0,       0,4};
    v[6]  = '{0,0,0,1,0,1, 0,32'h80,0,       0,1,1,0,1,1, 32'h80,D1,0,0,             0,0};
    v[7]  = '{0,0,0,1,1,0, 0,32'h84,32'h55AA55AA, 0,1,1,1,0,1, 32'h84,D1,0,32'h55AA55AA, 0,0};
    v[8]  = '{0,0,0,0,0,0, 0,0,0,            0,1,1,0,0,1, 0,D1,0,0,                  0,0};
    v[9]  = '{1,0,0,1,0,0, 0,0,32'h12345678, 0,0,1,0,0,0, 0,0,0,32'h12345678,       0,0};
    v[10] = '{1,0,0,0,0,0, 0,0,0,            1,0,1,0,0,1, 0,D0,0,0,                  0,1};
    v[11] = '{1,0,0,0,0,1, 0,0,0,            1,0,1,0,0,1, 0,D0,0,0,                  0,0};
    v[12] = '{1,0,0,0,0,0, 0,0,0,            1,0,1,0,0,1, 0,D0,0,0,                  1,0};
    v[13] = '{0,0,0,0,0,0, 0,0,0,            1,0,1,0,0,1, 0,D0,0,0,                  1,0};
    v[14] = '{0,0,0,0,0,0, 0,0,0,            0,0,1,0,0,0, 0,0,0,0,                   1,0};
    v[15] = '{0,0,0,0,0,0, 0,0,32'h0BADF00D, 0,0,0,0,0,1, 0,0,0,0,                   1,0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 16; i++) begin
      {m0_access, m0_rden, m0_wren, m1_access, m1_rden, m1_wren} = {v[i].a0, v[i].rd0, v[i].wr0, v[i].a1, v[i].rd1, v[i].wr1};
      m0_address = v[i].ad0;
      m1_address = v[i].ad1;
      fs_q = v[i].fsq;
      #1;
      chk($sformatf("row%0d m0_grant", i), 32'(m0_grant), 32'(v[i].g0));
      chk($sformatf("row%0d m1_grant", i), 32'(m1_grant), 32'(v[i].g1));
      chk($sformatf("row%0d fs_access", i), 32'(fs_access), 32'(v[i].acc));
      chk($sformatf("row%0d fs_rden", i), 32'(fs_rden), 32'(v[i].rd));
      chk($sformatf("row%0d fs_wren", i), 32'(fs_wren), 32'(v[i].wr));
      if (v[i].bus) begin
        chk($sformatf("row%0d fs_address", i), fs_address, v[i].ad);
        chk($sformatf("row%0d fs_data", i), fs_data, v[i].dt);
      end
      chk($sformatf("row%0d m0_q", i), m0_q, v[i].q0);
      chk($sformatf("row%0d m1_q", i), m1_q, v[i].q1);
      chk($sformatf("row%0d protocol_err", i), 32'(protocol_err), 32'(v[i].pe));
      chk($sformatf("row%0d m1_wait", i), 32'(m1_wait), 32'(v[i].wt1));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    m1_access = 1;
    tick();
    chk("idle m1 alone grant", 32'(m1_grant), 32'd1);
    m1_access = 0;
    tick();
    chk("m1 release drain", 32'(fs_access & ~m1_grant), 32'd1);
    tick();
    chk("back to idle", 32'(fs_access), 32'd0);
    m0_access = 1;
    m1_access = 1;
    tick();
    chk("idle tie m0_grant", 32'(m0_grant), 32'd1);
    chk("idle tie m1_grant", 32'(m1_grant), 32'd0);
    do_reset();
    chk("reset clears perr", 32'(protocol_err), 32'd0);
    m0_access = 1;
    tick();
    chk("conflict grant", 32'(m0_grant), 32'd1);
    {m0_rden, m0_wren, m0_meta} = 3'b111;
    #1;
    chk("conflict fs_wren", 32'(fs_wren), 32'd1);
    chk("conflict fs_rden", 32'(fs_rden), 32'd0);
    chk("conflict fs_meta", 32'(fs_meta), 32'd1);
    tick();
    chk("conflict perr", 32'(protocol_err), 32'd1);
    do_reset();
    m0_access = 1;
    m1_access = 1;
    repeat (70000) tick();
    chk("sat m0_grant", 32'(m0_grant), 32'd1);
    chk("sat m1_wait", 32'(m1_wait), 32'hFFFF);
    m0_access = 0;
    tick();
    chk("sat drain m1_wait", 32'(m1_wait), 32'hFFFF);
    chk("sat drain m1_grant", 32'(m1_grant), 32'd0);
    tick();
    chk("sat handover m1_grant", 32'(m1_grant), 32'd1);
    chk("sat handover m1_wait", 32'(m1_wait), 32'd0);
    do_reset();
    m0_access = 1;
    tick();
    m0_wren = 1;
    m0_address = 32'h100;
    #1;
    chk("pre-rst fs_wren", 32'(fs_wren), 32'd1);
    #1 rst = 1;
    m0_wren = 0;
    #1;
    chk("rst fs_wren", 32'(fs_wren), 32'd0);
    chk("rst fs_access", 32'(fs_access), 32'd0);
    chk("rst m0_grant", 32'(m0_grant), 32'd0);
    tick();
    rst = 0;
    #1;
    chk("post-rst idle grant", 32'(m0_grant), 32'd0);
    tick();
    chk("post-rst regrant", 32'(m0_grant), 32'd1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
